// File: rtl/cache_victim_select_if.sv
// rtl/cache_victim_select_if.sv - access/fill bus between the cache controller and the victim selector
interface cache_victim_select_if #(
  parameter int NUMWAYS = 4,
  parameter int SETLEN  = 9
);
  logic               flush_stage;
  logic               cache_en;
  logic               policy_sel;
  logic [NUMWAYS-1:0] valid_way;
  logic [NUMWAYS-1:0] lock_way;
  logic [SETLEN-1:0]  cache_set_data;
  logic [SETLEN-1:0]  padr;
  logic               lru_write_en;
  logic               set_valid;
  logic               invalidate_cache;
  logic [NUMWAYS-1:0] victim_way;
  logic               victim_avail;

  modport master (
    output flush_stage, cache_en, policy_sel, valid_way, lock_way,
           cache_set_data, padr, lru_write_en, set_valid, invalidate_cache,
    input  victim_way, victim_avail
  );

  modport slave (
    input  flush_stage, cache_en, policy_sel, valid_way, lock_way,
           cache_set_data, padr, lru_write_en, set_valid, invalidate_cache,
    output victim_way, victim_avail
  );
endinterface

// File: rtl/cache_victim_select.sv
// rtl/cache_victim_select.sv - per-set victim way selector: invalid-first, then LFSR or round-robin, lock-aware
module cache_victim_select #(
  parameter int NUMWAYS  = 4,
  parameter int SETLEN   = 9,
  parameter int NUMLINES = 128
) (
  input logic                 clk,
  input logic                 rst,
  cache_victim_select_if.slave bus
);
  localparam int L  = $clog2(NUMWAYS);
  localparam int W  = L + 2;
  localparam int IW = $clog2(NUMLINES);

  logic [W-1:0]       lfsr_q, lfsr_d;
  logic               fb;
  logic [L-1:0]       cur_ptr_q, cur_ptr_d;
  logic [L-1:0]       rr_ptr_q [NUMLINES];
  logic [NUMWAYS-1:0] cand;
  logic [L-1:0]       base, scan_idx, victim_idx, rr_wdata;
  logic [IW-1:0]      wr_idx, rd_idx;
  logic               fill, avail, rr_we;

  if (W == 3) begin : g_fb3
    assign fb = lfsr_q[2] ^ lfsr_q[1] ^ lfsr_q[0];
  end else if (W == 4) begin : g_fb4
    assign fb = lfsr_q[3] ^ lfsr_q[1] ^ lfsr_q[0];
  end else if (W == 5) begin : g_fb5
    assign fb = lfsr_q[4] ^ lfsr_q[1] ^ lfsr_q[0];
  end else if (W == 6) begin : g_fb6
    assign fb = lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
  end else if (W == 7) begin : g_fb7
    assign fb = lfsr_q[6] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[2] ^ lfsr_q[0];
  end else if (W == 8) begin : g_fb8
    assign fb = lfsr_q[7] ^ lfsr_q[6] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[2] ^ lfsr_q[1] ^ lfsr_q[0];
  end else begin : g_fb9
    assign fb = lfsr_q[8] ^ lfsr_q[7] ^ lfsr_q[6] ^ lfsr_q[5] ^ lfsr_q[2] ^ lfsr_q[1] ^ lfsr_q[0];
  end

  // Only the low set-index bits address the pointer table.
  if (SETLEN > IW) begin : g_unused_hi
    logic unused_hi;
    assign unused_hi = ^{bus.padr[SETLEN-1:IW], bus.cache_set_data[SETLEN-1:IW]};
  end

  assign wr_idx = bus.padr[IW-1:0];
  assign rd_idx = bus.cache_set_data[IW-1:0];

  // Descending scans so the lowest index / smallest offset from base wins.
  always_comb begin
    cand       = ~bus.valid_way & ~bus.lock_way;
    base       = bus.policy_sel ? cur_ptr_q : lfsr_q[L-1:0];
    scan_idx   = '0;
    victim_idx = '0;
    if (|cand) begin
      for (int i = NUMWAYS - 1; i >= 0; i--) begin
        if (cand[i]) victim_idx = L'(i);
      end
    end else begin
      for (int i = NUMWAYS - 1; i >= 0; i--) begin
        scan_idx = base + L'(i);
        if (!bus.lock_way[scan_idx]) victim_idx = scan_idx;
      end
    end
  end

  assign avail            = ~&bus.lock_way;
  assign bus.victim_avail = avail;
  assign bus.victim_way   = avail ? (NUMWAYS'(1) << victim_idx) : '0;

  assign fill     = bus.lru_write_en & bus.set_valid & ~bus.flush_stage;
  assign rr_we    = fill & avail & bus.policy_sel & ~|cand;
  assign rr_wdata = victim_idx + L'(1);

  always_comb begin
    lfsr_d = (bus.lru_write_en && !bus.flush_stage) ? {fb, lfsr_q[W-1:1]} : lfsr_q;
    cur_ptr_d = cur_ptr_q;
    if (bus.invalidate_cache) begin
      cur_ptr_d = '0;
    end else if (bus.cache_en) begin
      cur_ptr_d = (rr_we && rd_idx == wr_idx) ? rr_wdata : rr_ptr_q[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q    <= W'(1);
      cur_ptr_q <= '0;
      for (int i = 0; i < NUMLINES; i++) rr_ptr_q[i] <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      cur_ptr_q <= cur_ptr_d;
      if (bus.invalidate_cache) begin
        for (int i = 0; i < NUMLINES; i++) rr_ptr_q[i] <= '0;
      end else if (rr_we) begin
        rr_ptr_q[wr_idx] <= rr_wdata;
      end
    end
  end
endmodule

// File: tb/tb_cache_victim_select.sv
// tb/tb_cache_victim_select.sv - directed bench for cache_victim_select, 4 ways, 128 sets
module tb_cache_victim_select;
  logic clk;
  logic rst;
  int   passed;
  int   total;

  cache_victim_select_if #(.NUMWAYS(4), .SETLEN(9)) vif ();

  cache_victim_select #(.NUMWAYS(4), .SETLEN(9), .NUMLINES(128)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    vif.flush_stage      = 1'b0;
    vif.cache_en         = 1'b0;
    vif.policy_sel       = 1'b0;
    vif.valid_way        = 4'b1111;
    vif.lock_way         = 4'b0000;
    vif.cache_set_data   = '0;
    vif.padr             = '0;
    vif.lru_write_en     = 1'b0;
    vif.set_valid        = 1'b0;
    vif.invalidate_cache = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    total++; if (vif.victim_way !== 4'b0010) $display("FAIL reset_out_lfsr_base: got %b exp %b", vif.victim_way, 4'b0010); else passed++;
    vif.policy_sel = 1'b1;
    #1;
    total++; if (vif.victim_way !== 4'b0001) $display("FAIL reset_out_rr_base: got %b exp %b", vif.victim_way, 4'b0001); else passed++;
    do_reset();
    total++; if (dut.lfsr_q !== 4'b0001) $display("FAIL reset_lfsr: got %b exp %b", dut.lfsr_q, 4'b0001); else passed++;
    total++; if (dut.cur_ptr_q !== 2'd0) $display("FAIL reset_curptr: got %0d exp 0", dut.cur_ptr_q); else passed++;
  endtask

  task automatic test_fill_invalid();
    do_reset();
    vif.valid_way = 4'b1011;
    #1;
    total++; if (vif.victim_way !== 4'b0100) $display("FAIL invalid_first_victim: got %b exp %b", vif.victim_way, 4'b0100); else passed++;
    total++; if (vif.victim_avail !== 1'b1) $display("FAIL invalid_first_avail: got %b exp 1", vif.victim_avail); else passed++;
    vif.lru_write_en = 1'b1;
    vif.set_valid    = 1'b1;
    tick();
    idle();
    vif.valid_way = 4'b1011;
    vif.lock_way  = 4'b0100;
    #1;
    total++; if (dut.lfsr_q !== 4'b1000) $display("FAIL invalid_fill_lfsr: got %b exp %b", dut.lfsr_q, 4'b1000); else passed++;
    total++; if (dut.rr_ptr_q[0] !== 2'd0) $display("FAIL invalid_fill_rrptr: got %0d exp 0", dut.rr_ptr_q[0]); else passed++;
    total++; if (vif.victim_way !== 4'b0001) $display("FAIL invalid_locked_skip: got %b exp %b", vif.victim_way, 4'b0001); else passed++;
  endtask

  task automatic test_lfsr_sequence();
    logic [3:0] exp_v [6];
    exp_v = '{4'b0010, 4'b0001, 4'b0001, 4'b0100, 4'b1000, 4'b1000};
    do_reset();
    vif.lru_write_en = 1'b1;
    vif.set_valid    = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      total++; if (vif.victim_way !== exp_v[k]) $display("FAIL lfsr_victim_%0d: got %b exp %b", k, vif.victim_way, exp_v[k]); else passed++;
      tick();
    end
    idle();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_v;
    do_reset();
    vif.policy_sel     = 1'b1;
    vif.padr           = 9'd5;
    vif.cache_set_data = 9'd5;
    vif.cache_en       = 1'b1;
    vif.lru_write_en   = 1'b1;
    vif.set_valid      = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      exp_v = 4'b0001 << (k % 4);
      total++; if (vif.victim_way !== exp_v) $display("FAIL rr_victim_%0d: got %b exp %b", k, vif.victim_way, exp_v); else passed++;
      tick();
    end
    total++; if (dut.rr_ptr_q[5] !== 2'd1) $display("FAIL rr_ptr5_wrap: got %0d exp 1", dut.rr_ptr_q[5]); else passed++;
    total++; if (dut.rr_ptr_q[6] !== 2'd0) $display("FAIL rr_ptr6_untouched: got %0d exp 0", dut.rr_ptr_q[6]); else passed++;
    total++; if (dut.cur_ptr_q !== 2'd1) $display("FAIL rr_curptr: got %0d exp 1", dut.cur_ptr_q); else passed++;
  endtask

  task automatic test_locks();
    total++; if (vif.victim_way !== 4'b0010) $display("FAIL lock_setup_victim: got %b exp %b", vif.victim_way, 4'b0010); else passed++;
    tick();
    vif.lru_write_en = 1'b0;
    vif.set_valid    = 1'b0;
    vif.lock_way     = 4'b0110;
    #1;
    total++; if (dut.rr_ptr_q[5] !== 2'd2) $display("FAIL lock_setup_ptr: got %0d exp 2", dut.rr_ptr_q[5]); else passed++;
    total++; if (vif.victim_way !== 4'b1000) $display("FAIL lock_skip_victim: got %b exp %b", vif.victim_way, 4'b1000); else passed++;
    vif.lock_way = 4'b1111;
    #1;
    total++; if (vif.victim_way !== 4'b0000) $display("FAIL all_locked_victim: got %b exp %b", vif.victim_way, 4'b0000); else passed++;
    total++; if (vif.victim_avail !== 1'b0) $display("FAIL all_locked_avail: got %b exp 0", vif.victim_avail); else passed++;
    vif.lru_write_en = 1'b1;
    vif.set_valid    = 1'b1;
    tick();
    idle();
    total++; if (dut.rr_ptr_q[5] !== 2'd2) $display("FAIL all_locked_ptr: got %0d exp 2", dut.rr_ptr_q[5]); else passed++;
    total++; if (dut.cur_ptr_q !== 2'd2) $display("FAIL all_locked_curptr: got %0d exp 2", dut.cur_ptr_q); else passed++;
  endtask

  task automatic test_flush_invalidate();
    do_reset();
    vif.policy_sel   = 1'b1;
    vif.padr         = 9'd5;
    vif.lru_write_en = 1'b1;
    vif.set_valid    = 1'b1;
    tick();
    vif.flush_stage = 1'b1;
    tick();
    total++; if (dut.rr_ptr_q[5] !== 2'd1) $display("FAIL flush_ptr: got %0d exp 1", dut.rr_ptr_q[5]); else passed++;
    total++; if (dut.lfsr_q !== 4'b1000) $display("FAIL flush_lfsr: got %b exp %b", dut.lfsr_q, 4'b1000); else passed++;
    vif.flush_stage      = 1'b0;
    vif.invalidate_cache = 1'b1;
    vif.cache_en         = 1'b1;
    vif.cache_set_data   = 9'd5;
    tick();
    idle();
    total++; if (dut.rr_ptr_q[5] !== 2'd0) $display("FAIL inval_ptr: got %0d exp 0", dut.rr_ptr_q[5]); else passed++;
    total++; if (dut.cur_ptr_q !== 2'd0) $display("FAIL inval_curptr: got %0d exp 0", dut.cur_ptr_q); else passed++;
    total++; if (dut.lfsr_q !== 4'b1100) $display("FAIL inval_lfsr: got %b exp %b", dut.lfsr_q, 4'b1100); else passed++;
  endtask

  task automatic test_bypass_reset();
    do_reset();
    vif.policy_sel     = 1'b1;
    vif.padr           = 9'd9;
    vif.cache_set_data = 9'd9;
    vif.cache_en       = 1'b1;
    vif.lru_write_en   = 1'b1;
    vif.set_valid      = 1'b1;
    tick();
    total++; if (dut.cur_ptr_q !== 2'd1) $display("FAIL bypass_curptr: got %0d exp 1", dut.cur_ptr_q); else passed++;
    total++; if (dut.rr_ptr_q[9] !== 2'd1) $display("FAIL bypass_ptr9: got %0d exp 1", dut.rr_ptr_q[9]); else passed++;
    tick();
    rst = 1'b1;
    #2;
    total++; if (dut.lfsr_q !== 4'b0001) $display("FAIL midreset_lfsr: got %b exp %b", dut.lfsr_q, 4'b0001); else passed++;
    total++; if (dut.rr_ptr_q[9] !== 2'd0) $display("FAIL midreset_ptr9: got %0d exp 0", dut.rr_ptr_q[9]); else passed++;
    total++; if (vif.victim_way !== 4'b0001) $display("FAIL midreset_victim: got %b exp %b", vif.victim_way, 4'b0001); else passed++;
    tick();
    rst = 1'b0;
    idle();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    idle();
    test_reset();
    test_fill_invalid();
    test_lfsr_sequence();
    test_round_robin();
    test_locks();
    test_flush_invalidate();
    test_bypass_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
